// File: rtl/rangefinder_sample_capture_writer_if.sv
// Port-2 write bus of the dual-port sample RAM.
// The capture writer drives it (master) and the RAM consumes it (slave).
interface rangefinder_sample_capture_writer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address2;
    logic              chipselect2;
    logic              write2;
    logic [DATA_W-1:0] writedata2;
    logic              clken2;
    logic              reset_req2;

    modport master (output address2, chipselect2, write2, writedata2, clken2, reset_req2);
    modport slave  (input  address2, chipselect2, write2, writedata2, clken2, reset_req2);
endinterface

// File: rtl/rangefinder_sample_capture_writer.sv
// Write-side master for port 2 of the sample RAM: arm, wait for trigger, stream decimated samples.
// Optional CAPTURE_PEAK_EN adds peak_value/peak_addr tracking of the largest written sample.
module rangefinder_sample_capture_writer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                arm,
    input  logic                                abort,
    input  logic                                trigger,
    input  logic [7:0]                          decim,
    input  logic [ADDR_W:0]                     num_samples,
    input  logic                                sample_valid,
    input  logic [DATA_W-1:0]                   sample_data,
    rangefinder_sample_capture_writer_if.master ram,
    output logic                                busy,
    output logic                                done,
    output logic                                irq,
    output logic [ADDR_W:0]                     count
`ifdef CAPTURE_PEAK_EN
    ,
    output logic [DATA_W-1:0]                   peak_value,
    output logic [ADDR_W-1:0]                   peak_addr
`endif
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t            state;
    logic [7:0]        decim_q;
    logic [7:0]        dcnt;
    logic [ADDR_W:0]   num_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0]   committed;
    logic              accept;
    logic              last_write;

    // committed includes a write that is registered but not yet counted, so the
    // final sample is never over-accepted during back-to-back streaming.
    assign committed  = count + {{ADDR_W{1'b0}}, wr_q};
    assign accept     = sample_valid && (dcnt == 8'd0) && (committed < num_q);
    assign last_write = wr_q && ((count + ONE) == num_q);

    // The write address is simply the number of samples already written.
    assign ram.address2    = count[ADDR_W-1:0];
    assign ram.write2      = wr_q;
    assign ram.chipselect2 = wr_q;
    assign ram.writedata2  = wdata_q;
    assign ram.clken2      = 1'b1;
    assign ram.reset_req2  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            decim_q <= '0;
            dcnt    <= '0;
            num_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            irq     <= 1'b0;
`ifdef CAPTURE_PEAK_EN
            peak_value <= '0;
            peak_addr  <= '0;
`endif
        end else begin
            irq  <= 1'b0;
            wr_q <= 1'b0;
            if (wr_q)
                count <= count + ONE;
            // abort beats everything, but an already-raised write strobe still finishes
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            state   <= S_ARMED;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            decim_q <= decim;
                            num_q   <= (num_samples == '0 || num_samples > DEPTH) ? DEPTH : num_samples;
                            count   <= '0;
`ifdef CAPTURE_PEAK_EN
                            peak_value <= '0;
                            peak_addr  <= '0;
`endif
                        end
                    end
                    S_ARMED: begin
                        if (trigger) begin
                            state <= S_CAPTURE;
                            dcnt  <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (sample_valid)
                            dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
                        if (accept) begin
                            wr_q    <= 1'b1;
                            wdata_q <= sample_data;
`ifdef CAPTURE_PEAK_EN
                            if (sample_data > peak_value) begin
                                peak_value <= sample_data;
                                peak_addr  <= committed[ADDR_W-1:0];
                            end
`endif
                        end
                        if (last_write) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            irq   <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rangefinder_sample_capture_writer.sv
// Self-checking bench: table of capture scenarios, hand-written corner sequences,
// and randomized captures checked against a queue-based reference model.
module tb_rangefinder_sample_capture_writer;
    logic       clk = 1'b0;
    logic       reset;
    logic       arm;
    logic       abort;
    logic       trigger;
    logic [7:0] decim;
    logic [8:0] num_samples;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       busy;
    logic       done;
    logic       irq;
    logic [8:0] count;
`ifdef CAPTURE_PEAK_EN
    logic [7:0] peak_value;
    logic [7:0] peak_addr;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int irq_cnt      = 0;

    logic [7:0]  stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    typedef struct {
        logic [7:0] decim;
        logic [8:0] num;
        int         nsent;
        logic [7:0] base;
        int         exp_count;
        bit         exp_done;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    rangefinder_sample_capture_writer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rangefinder_sample_capture_writer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .trigger      (trigger),
        .decim        (decim),
        .num_samples  (num_samples),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ram          (bus.master),
        .busy         (busy),
        .done         (done),
        .irq          (irq),
        .count        (count)
`ifdef CAPTURE_PEAK_EN
        ,
        .peak_value   (peak_value),
        .peak_addr    (peak_addr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Record every RAM write and every irq cycle, as the RAM and CPU would see them.
    always @(negedge clk) begin
        if (bus.write2 === 1'b1) begin
            obs_q.push_back({bus.address2, bus.writedata2});
            checkOutput("chipselect2", 32'(bus.chipselect2), 32'd1);
        end
        if (irq === 1'b1)
            irq_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: the k-th valid sample after trigger is kept when k is a multiple of
    // decim+1, until the (normalised) sample budget is used; kept samples go to 0,1,2...
    task automatic buildExpected(input logic [7:0] d, input logic [8:0] n);
        int limit;
        limit = (n == 9'd0 || n > 9'd256) ? 256 : int'(n);
        exp_q.delete();
        for (int k = 0; k < stim_q.size(); k++)
            if ((k % (int'(d) + 1)) == 0 && exp_q.size() < limit)
                exp_q.push_back({8'(exp_q.size()), stim_q[k]});
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [8:0] n, input int max_gap);
        obs_q.delete();
        irq_cnt     = 0;
        decim       = d;
        num_samples = n;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
        decim       = 8'hFF;
        num_samples = 9'd7;
        trigger      = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 8'hEE;
        tick();
        trigger      = 1'b0;
        sample_valid = 1'b0;
        foreach (stim_q[i]) begin
            repeat ($urandom_range(0, max_gap)) tick();
            sample_valid = 1'b1;
            sample_data  = stim_q[i];
            tick();
            sample_valid = 1'b0;
            sample_data  = 8'($urandom);
        end
        repeat (3) tick();
    endtask

    task automatic checkCapture(input string tag, input int exp_count, input bit exp_done);
        checkOutput({tag, ".nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput({tag, ".write"}, 32'(obs_q[i]), 32'(exp_q[i]));
        checkOutput({tag, ".count"}, 32'(count), 32'(exp_count));
        checkOutput({tag, ".done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(!exp_done));
        checkOutput({tag, ".irq_pulses"}, 32'(irq_cnt), exp_done ? 32'd1 : 32'd0);
        checkOutput({tag, ".address2"}, 32'(bus.address2), 32'(exp_count % 256));
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        trigger      = 1'b0;
        decim        = 8'd0;
        num_samples  = 9'd0;
        sample_valid = 1'b0;
        sample_data  = 8'd0;

        vecs[0] = '{8'd0, 9'd4,   5,   8'd10, 4,   1'b1, 8'd13};
        vecs[1] = '{8'd2, 9'd3,   9,   8'd1,  3,   1'b1, 8'd7};
        vecs[2] = '{8'd0, 9'd0,   256, 8'd0,  256, 1'b1, 8'd255};
        vecs[3] = '{8'd1, 9'd5,   6,   8'd20, 3,   1'b0, 8'd24};
        vecs[4] = '{8'd0, 9'd300, 256, 8'd0,  256, 1'b1, 8'd255};
        vecs[5] = '{8'd3, 9'd2,   10,  8'd50, 2,   1'b1, 8'd54};

        repeat (2) tick();
        checkOutput("rst.write2", 32'(bus.write2), 32'd0);
        checkOutput("rst.chipselect2", 32'(bus.chipselect2), 32'd0);
        checkOutput("rst.address2", 32'(bus.address2), 32'd0);
        checkOutput("rst.writedata2", 32'(bus.writedata2), 32'd0);
        checkOutput("rst.clken2", 32'(bus.clken2), 32'd1);
        checkOutput("rst.reset_req2", 32'(bus.reset_req2), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.irq", 32'(irq), 32'd0);
        checkOutput("rst.count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            stim_q.delete();
            for (int i = 0; i < vecs[v].nsent; i++)
                stim_q.push_back(8'(int'(vecs[v].base) + i));
            applyStimulus(vecs[v].decim, vecs[v].num, 0);
            buildExpected(vecs[v].decim, vecs[v].num);
            checkCapture($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_done);
            if (obs_q.size() > 0)
                checkOutput($sformatf("vec%0d.last_data", v), 32'(obs_q[obs_q.size()-1][7:0]), 32'(vecs[v].exp_last));
            if (!vecs[v].exp_done) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                tick();
                checkOutput("abort_capture.busy", 32'(busy), 32'd0);
                checkOutput("abort_capture.count_hold", 32'(count), 32'(vecs[v].exp_count));
            end
        end

        // reset in the middle of a capture with a write pending
        arm = 1'b1; decim = 8'd0; num_samples = 9'd10; tick(); arm = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h21; tick();
        sample_data = 8'h22; tick();
        sample_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("midrst.write2", 32'(bus.write2), 32'd0);
        checkOutput("midrst.address2", 32'(bus.address2), 32'd0);
        checkOutput("midrst.count", 32'(count), 32'd0);
        checkOutput("midrst.done", 32'(done), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        tick();

        // trigger with no arm, samples while armed without trigger, arm during capture
        obs_q.delete(); irq_cnt = 0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h55; tick(); sample_valid = 1'b0;
        checkOutput("noarm.busy", 32'(busy), 32'd0);
        arm = 1'b1; decim = 8'd0; num_samples = 9'd3; tick(); arm = 1'b0;
        checkOutput("armed.busy", 32'(busy), 32'd1);
        sample_valid = 1'b1; sample_data = 8'h66; repeat (2) tick(); sample_valid = 1'b0;
        tick();
        checkOutput("armed.no_write", 32'(obs_q.size()), 32'd0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 8'hA1; tick();
        arm = 1'b1; decim = 8'd5; num_samples = 9'd1; sample_data = 8'hA2; tick(); arm = 1'b0;
        sample_data = 8'hA3; tick(); sample_valid = 1'b0;
        repeat (3) tick();
        stim_q.delete();
        stim_q.push_back(8'hA1); stim_q.push_back(8'hA2); stim_q.push_back(8'hA3);
        buildExpected(8'd0, 9'd3);
        checkCapture("rearm_ignored", 3, 1'b1);

        // abort while armed: nothing written, back to idle
        obs_q.delete();
        arm = 1'b1; num_samples = 9'd2; decim = 8'd0; tick(); arm = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        checkOutput("abort_armed.busy", 32'(busy), 32'd0);
        checkOutput("abort_armed.done", 32'(done), 32'd0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h77; tick(); sample_valid = 1'b0;
        repeat (2) tick();
        checkOutput("abort_armed.no_write", 32'(obs_q.size()), 32'd0);
        checkOutput("abort_armed.busy_after", 32'(busy), 32'd0);

        // abort on the cycle a write strobe is up: the strobe completes, nothing more
        obs_q.delete();
        arm = 1'b1; num_samples = 9'd4; decim = 8'd0; tick(); arm = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 8'h33; tick();
        checkOutput("abort_pend.write2", 32'(bus.write2), 32'd1);
        abort = 1'b1; sample_data = 8'h44; tick();
        abort = 1'b0; sample_valid = 1'b0;
        checkOutput("abort_pend.write2_after", 32'(bus.write2), 32'd0);
        checkOutput("abort_pend.busy", 32'(busy), 32'd0);
        tick();
        checkOutput("abort_pend.nwrites", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0)
            checkOutput("abort_pend.write", 32'(obs_q[0]), 32'h0033);

`ifdef CAPTURE_PEAK_EN
        stim_q.delete();
        stim_q.push_back(8'd5); stim_q.push_back(8'd200);
        stim_q.push_back(8'd17); stim_q.push_back(8'd200);
        applyStimulus(8'd0, 9'd4, 0);
        checkOutput("peak.value", 32'(peak_value), 32'd200);
        checkOutput("peak.addr", 32'(peak_addr), 32'd1);
`endif

        // randomized captures with idle gaps between valid samples
        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            logic [8:0] n;
            int total;
            d = 8'($urandom_range(0, 3));
            n = 9'($urandom_range(1, 24));
            total = int'(n) * (int'(d) + 1) + int'($urandom_range(0, 4));
            stim_q.delete();
            for (int i = 0; i < total; i++)
                stim_q.push_back(8'($urandom));
            applyStimulus(d, n, 2);
            buildExpected(d, n);
            checkCapture($sformatf("rand%0d", r), int'(n), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
